// File: rtl/encrypter_collector_pkg.sv
// rtl/encrypter_collector_pkg.sv - shared types and helpers for the encrypter result collector
// Contents: collector FSM state encoding, nibble width, counter-width helper.
package encrypter_collector_pkg;

  localparam int NIBBLE_W = 4;

  // Encodings 2 and 3 are unused; the FSM recovers them to COLLECTOR_IDLE.
  typedef enum logic [1:0] {
    COLLECTOR_IDLE  = 2'd0,
    COLLECTOR_SHIFT = 2'd1
  } collector_state_e;

  // Width of a counter indexing n items, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/encrypter_collector_if.sv
// rtl/encrypter_collector_if.sv - encrypter result bank and QSPI nibble stream bundle
// Signals: result_data/result_valid/result_ack (encrypter channels),
//          qspi_out_data/valid/ready/last (nibble stream).
// Modports: master = collector, slave = encrypter bank plus QSPI transmitter.
interface encrypter_collector_if
  import encrypter_collector_pkg::*;
#(
  parameter int NUM_ENCRYPTERS  = 4,
  parameter int ENCRYPTER_WIDTH = 32
) ();

  logic [NUM_ENCRYPTERS*ENCRYPTER_WIDTH-1:0] result_data;
  logic [NUM_ENCRYPTERS-1:0]                 result_valid;
  logic [NUM_ENCRYPTERS-1:0]                 result_ack;
  logic [NIBBLE_W-1:0]                       qspi_out_data;
  logic                                      qspi_out_valid;
  logic                                      qspi_out_ready;
  logic                                      qspi_out_last;

  modport master (
    input  result_data, result_valid, qspi_out_ready,
    output result_ack, qspi_out_data, qspi_out_valid, qspi_out_last
  );

  modport slave (
    output result_data, result_valid, qspi_out_ready,
    input  result_ack, qspi_out_data, qspi_out_valid, qspi_out_last
  );

endinterface

// File: rtl/encrypter_collector_nibble_serializer.sv
// rtl/encrypter_collector_nibble_serializer.sv - MSB-first nibble shifter with valid/ready
// Ports: clk, reset (sync, active-high), load_i/load_data_i (capture a packet),
//        ready_i (downstream accept), data_o/valid_o/last_o (registered stream),
//        done_o (handshake of the final nibble this cycle).
module encrypter_collector_nibble_serializer
  import encrypter_collector_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_i,
  input  logic [WIDTH-1:0]    load_data_i,
  input  logic                ready_i,
  output logic [NIBBLE_W-1:0] data_o,
  output logic                valid_o,
  output logic                last_o,
  output logic                done_o
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = cnt_width(NIBBLES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NIBBLES - 1);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             handshake;

  assign handshake = valid_q && ready_i;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (load_i) begin
      shift_d = load_data_i;
      cnt_d   = '0;
      valid_d = 1'b1;
      last_d  = (NIBBLES == 1);
    end else if (handshake) begin
      shift_d = shift_q << NIBBLE_W;
      cnt_d   = cnt_q + 1'b1;
      if (last_q) begin
        valid_d = 1'b0;
        last_d  = 1'b0;
      end else begin
        // last is registered, so it is raised as the counter reaches the final index
        last_d = (cnt_d == LAST_IDX);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign data_o  = shift_q[WIDTH-1 -: NIBBLE_W];
  assign valid_o = valid_q;
  assign last_o  = last_q;
  assign done_o  = handshake && last_q;

endmodule

// File: rtl/encrypter_collector.sv
// rtl/encrypter_collector.sv - strict round-robin collector of encrypter results onto a QSPI nibble stream
// Ports: clk, reset (sync, active-high), sync (restart ordering at channel 0),
//        bus (encrypter_collector_if.master: results in, acks out, nibble stream out),
//        busy, state_out, encrypter_index_out (observation of FSM and channel pointer).
module encrypter_collector
  import encrypter_collector_pkg::*;
#(
  parameter int NUM_ENCRYPTERS  = 4,
  parameter int ENCRYPTER_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              sync,
  encrypter_collector_if.master             bus,
  output logic                              busy,
  output logic [1:0]                        state_out,
  output logic [$clog2(NUM_ENCRYPTERS)-1:0] encrypter_index_out
);

  localparam int PTR_W = $clog2(NUM_ENCRYPTERS);

  if (ENCRYPTER_WIDTH % NIBBLE_W != 0 || ENCRYPTER_WIDTH < NIBBLE_W) begin : g_bad_width
    $error("encrypter_collector: ENCRYPTER_WIDTH must be a positive multiple of 4");
  end
  if (NUM_ENCRYPTERS < 2) begin : g_bad_count
    $error("encrypter_collector: NUM_ENCRYPTERS must be at least 2");
  end

  collector_state_e          state_q, state_d;
  logic [PTR_W-1:0]          ptr_q, ptr_d, ptr_next;
  logic                      sync_pending_q, sync_pending_d;
  logic [NUM_ENCRYPTERS-1:0] ack_q, ack_d;
  logic                      load;
  logic                      done;

  assign ptr_next = (ptr_q == PTR_W'(NUM_ENCRYPTERS - 1)) ? '0 : ptr_q + 1'b1;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= COLLECTOR_IDLE;
      ptr_q          <= '0;
      sync_pending_q <= 1'b0;
      ack_q          <= '0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      sync_pending_q <= sync_pending_d;
      ack_q          <= ack_d;
    end
  end

  // Next state: only channel ptr is ever considered, which keeps output order equal to deal order.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    sync_pending_d = sync_pending_q;
    ack_d          = '0;
    load           = 1'b0;
    case (state_q)
      COLLECTOR_IDLE: begin
        if (sync) begin
          ptr_d          = '0;
          sync_pending_d = 1'b0;
        end else if (bus.result_valid[ptr_q]) begin
          load         = 1'b1;
          ack_d[ptr_q] = 1'b1;
          state_d      = COLLECTOR_SHIFT;
        end
      end
      COLLECTOR_SHIFT: begin
        // A sync mid-packet is deferred so the packet in flight is never torn.
        if (sync) begin
          sync_pending_d = 1'b1;
        end
        if (done) begin
          state_d        = COLLECTOR_IDLE;
          ptr_d          = (sync_pending_q || sync) ? '0 : ptr_next;
          sync_pending_d = 1'b0;
        end
      end
      default: begin
        state_d = COLLECTOR_IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    busy                = (state_q != COLLECTOR_IDLE);
    state_out           = state_q;
    encrypter_index_out = ptr_q;
    bus.result_ack      = ack_q;
  end

  logic [NIBBLE_W-1:0] ser_data;
  logic                ser_valid;
  logic                ser_last;

  encrypter_collector_nibble_serializer #(
    .WIDTH (ENCRYPTER_WIDTH)
  ) u_serializer (
    .clk         (clk),
    .reset       (reset),
    .load_i      (load),
    .load_data_i (bus.result_data[ptr_q*ENCRYPTER_WIDTH +: ENCRYPTER_WIDTH]),
    .ready_i     (bus.qspi_out_ready),
    .data_o      (ser_data),
    .valid_o     (ser_valid),
    .last_o      (ser_last),
    .done_o      (done)
  );

  assign bus.qspi_out_data  = ser_data;
  assign bus.qspi_out_valid = ser_valid;
  assign bus.qspi_out_last  = ser_last;

endmodule

// File: doc/encrypter_collector.md
Name: encrypter_collector

Overview:
Result-side scheduler for the encrypter bank. The Parallelizer deals data packets round-robin to NUM_ENCRYPTERS encrypters. This block collects the encrypted packets in the same strict round-robin order and arbitrates them onto a single 4-bit QSPI output stream, so output order equals input order. It sits between the encrypter bank and the QSPI transmit interface.

Parameters:
NUM_ENCRYPTERS, 4, number of encrypter result channels (>=2)
ENCRYPTER_WIDTH, 32, bits per encrypted packet; must be a multiple of 4 (elaboration-time error otherwise)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
result_data  input  NUM_ENCRYPTERS*ENCRYPTER_WIDTH  flattened results; channel i at [i*ENCRYPTER_WIDTH +: ENCRYPTER_WIDTH]
result_valid  input  NUM_ENCRYPTERS  channel i holds a finished packet
result_ack  output  NUM_ENCRYPTERS  one-cycle pulse: channel i packet captured
sync  input  1  restart ordering at channel 0 (pulsed by Parallelizer on prog / new stream)
qspi_out_data  output  4  current nibble, MSB nibble first
qspi_out_valid  output  1  nibble valid
qspi_out_ready  input  1  downstream accepts nibble
qspi_out_last  output  1  high with final nibble of a packet
busy  output  1  state != IDLE
state_out  output  2  watcher: FSM state
encrypter_index_out  output  $clog2(NUM_ENCRYPTERS)  watcher: channel pointer

Behaviour:
- Reset (clk edge with reset=1): state IDLE, ptr 0, sync_pending 0, result_ack 0, qspi_out_valid 0, qspi_out_data 0, qspi_out_last 0, shift reg 0, nibble count 0. Reset overrides every other input, including mid-SHIFT. The partial packet is dropped and no ack is issued.
- NIBBLES = ENCRYPTER_WIDTH/4. Nibble counter width is $clog2(NIBBLES). The ptr wraps from NUM_ENCRYPTERS-1 to 0.
- States: IDLE=0, SHIFT=1. Encoding 2 and 3 are unused and recover to IDLE.
- IDLE:
  - If sync=1: ptr<=0, sync_pending<=0, no capture this cycle.
  - Else if result_valid[ptr]=1: shift<=channel ptr data, result_ack[ptr]<=1 for exactly the next cycle, nib_cnt<=0, state<=SHIFT.
  - result_valid on any channel other than ptr is ignored, with no ack. The block waits indefinitely for channel ptr.
- SHIFT:
  - qspi_out_valid=1. qspi_out_data=shift[W-1:W-4]. qspi_out_last=(nib_cnt==NIBBLES-1). All outputs are registered.
  - On an edge with valid&&ready: shift<<=4 and nib_cnt++.
  - On the last-nibble handshake: state<=IDLE, valid/last drop next cycle. ptr<=0 if sync_pending, else ptr+1 with wrap. sync_pending<=0.
  - While qspi_out_ready=0: data, last and valid hold stable.
  - sync=1 in SHIFT sets sync_pending; it does not abort the packet. sync on the same edge as the last handshake also resolves to ptr 0.
  - result_valid is ignored in SHIFT.
- Encrypter contract: drop result_valid in the cycle result_ack is seen high. The collector never re-acks the same channel before leaving SHIFT.
- Latency:
  - Valid seen at edge N gives ack and first nibble valid from edge N+1.
  - With ready held high, the packet occupies NIBBLES cycles, plus 1 IDLE cycle between packets.
- result_ack is one-hot or zero at all times.

Decomposition:
- Shared constants in constants.vh: ENCRYPTER_WIDTH, NUM_ENCRYPTERS, NUM_ENCRYPTERS_REG, ENCRYPTER_QSPI_COUNT_REG (nibble counter width), plus new COLLECTOR_IDLE/COLLECTOR_SHIFT state defines.
- One sub-module: nibble_serializer.
  - Function: load, MSB-first 4-bit shift with valid/ready, last flag and done pulse.
  - Top level keeps the FSM, pointer, sync handling and ack generation.

Test Plan:
1. Reset; ch0 result_valid with 0x12345678, ready=1 -> result_ack=0001 for 1 cycle; out nibbles 1,2,3,4,5,6,7,8 on 8 consecutive cycles; last on 8; ptr=1.
2. After reset, ch1 valid (0xAAAAAAAA) 5 cycles before ch0 (0x55555555) -> no ack to ch1 until ch0 done; stream is 5×8 then A×8; ack order 0001 then 0010.
3. ch0=0xDEADBEEF, ready alternating 1,0 -> each nibble stable while ready=0; 8 nibbles D,E,A,D,B,E,E,F over 15 cycles; last only on F.
4. Five packets valid on ch0,ch1,ch2,ch3,ch0 -> encrypter_index_out sequence 0,1,2,3,0; ack sequence 0001,0010,0100,1000,0001.
5. sync pulse during nibble 3 of ch1 packet -> ch1 packet completes all 8 nibbles; next ptr=0, not 2; ch2 valid ignored.
6. reset asserted during nibble 4 of ch2 packet -> next cycle valid=0, last=0, busy=0, ptr=0, no further ack to ch2.
